// File: rtl/serial_subtractor_if.sv
// Handshake and operand/result bundle for the bit-serial subtractor.
// The master drives the request and operands; the slave returns status and result.
interface serial_subtractor_if #(
    parameter int unsigned WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             bout;

    modport master (
        output start, a, b, bin,
        input  busy, done, diff, bout
    );

    modport slave (
        input  start, a, b, bin,
        output busy, done, diff, bout
    );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor: diff = a - b - bin, one bit per clock, LSB first.
// diff/bout are registered and only change on the edge that enters DONE.
module serial_subtractor #(
    parameter int unsigned WIDTH = 8
) (
    input logic                clk,
    input logic                rst_n,
    serial_subtractor_if.slave bus
);
    localparam int unsigned CntW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StDone
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             br_q, br_d;
    logic             bout_q, bout_d;
    logic [CntW-1:0]  cnt_q, cnt_d;

    logic             a0, b0;
    logic             d_bit;
    logic             br_next;
    logic [WIDTH-1:0] res_shifted;

    // One full-subtractor slice operating on the current LSBs.
    always_comb begin
        a0          = a_q[0];
        b0          = b_q[0];
        d_bit       = a0 ^ b0 ^ br_q;
        br_next     = (~a0 & b0) | (~(a0 ^ b0) & br_q);
        res_shifted = {d_bit, res_q[WIDTH-1:1]};
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        diff_d  = diff_q;
        br_d    = br_q;
        bout_d  = bout_q;
        cnt_d   = cnt_q;

        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    a_d     = bus.a;
                    b_d     = bus.b;
                    br_d    = bus.bin;
                    res_d   = '0;
                    cnt_d   = '0;
                    state_d = StShift;
                end
            end
            StShift: begin
                a_d   = a_q >> 1;
                b_d   = b_q >> 1;
                br_d  = br_next;
                res_d = res_shifted;
                cnt_d = cnt_q + CntW'(1);
                if (cnt_q == CntLast) begin
                    diff_d  = res_shifted;
                    bout_d  = br_next;
                    state_d = StDone;
                end
            end
            StDone: begin
                // start is deliberately not sampled here.
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            diff_q  <= '0;
            br_q    <= 1'b0;
            bout_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            diff_q  <= diff_d;
            br_q    <= br_d;
            bout_q  <= bout_d;
            cnt_q   <= cnt_d;
        end
    end

    // Status decodes straight from the state flops, so no input reaches an output.
    assign bus.busy = (state_q == StShift);
    assign bus.done = (state_q == StDone);
    assign bus.diff = diff_q;
    assign bus.bout = bout_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor: arithmetic reference model checked every cycle,
// plus literal expectations for the hand-computed vectors.
module tb_serial_subtractor;
    localparam int W = 8;

    logic clk;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;
    int   done_cnt = 0;
    int   cyc = 0;
    bit   model_on = 1'b0;

    serial_subtractor_if #(.WIDTH(W)) bus ();

    serial_subtractor #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running want finished");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [W:0] sub_ref(input logic [W-1:0] x, input logic [W-1:0] y,
                                           input logic bi);
        return {1'b0, x} - {1'b0, y} - {{W{1'b0}}, bi};
    endfunction

    // Reference model: edges since the accepting edge, result known at accept time.
    int         phase = -1;
    logic [W:0] pend = '0;
    logic [W-1:0] m_diff = '0;
    logic       m_bout = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase  <= -1;
            m_diff <= '0;
            m_bout <= 1'b0;
        end else if (phase < 0) begin
            if (bus.start === 1'b1) begin
                phase <= 0;
                pend  <= sub_ref(bus.a, bus.b, bus.bin);
            end
        end else begin
            if (phase + 1 == W) {m_bout, m_diff} <= pend;
            phase <= (phase + 1 == W + 1) ? -1 : phase + 1;
        end
    end

    always @(negedge clk) begin
        cyc++;
        if (bus.done === 1'b1) done_cnt++;
        if (model_on) begin
            check("busy", 32'(bus.busy), 32'(phase >= 0 && phase < W));
            check("done", 32'(bus.done), 32'(phase == W));
            check("diff", 32'(bus.diff), 32'(m_diff));
            check("bout", 32'(bus.bout), 32'(m_bout));
        end
    end

    // Issue one operation and wait (bounded) for its done pulse.
    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tbin,
                          input logic [W-1:0] ed, input logic eb, input string name);
        int busy_cycles = 0;
        bit seen = 1'b0;
        check({name, " model"}, 32'(sub_ref(ta, tb_v, tbin)), 32'({eb, ed}));
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = ta;
        bus.b     = tb_v;
        bus.bin   = tbin;
        @(negedge clk);
        bus.start = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            if (bus.done === 1'b1) seen = 1'b1;
            else begin
                if (bus.busy === 1'b1) busy_cycles++;
                @(negedge clk);
            end
        end
        check({name, " done seen"}, 32'(seen), 32'd1);
        check({name, " busy cycles"}, 32'(busy_cycles), 32'(W));
        check({name, " diff"}, 32'(bus.diff), 32'(ed));
        check({name, " bout"}, 32'(bus.bout), 32'(eb));
    endtask

    initial begin
        int d0;
        int last_done;
        int ndone;

        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        bus.bin   = 1'b0;
        repeat (3) @(negedge clk);
        check("reset busy", 32'(bus.busy), 32'd0);
        check("reset done", 32'(bus.done), 32'd0);
        check("reset diff", 32'(bus.diff), 32'd0);
        check("reset bout", 32'(bus.bout), 32'd0);
        rst_n    = 1'b1;
        model_on = 1'b1;

        run_op(8'h0F, 8'h0C, 1'b1, 8'h02, 1'b0, "op0f0c");
        run_op(8'h03, 8'h09, 1'b0, 8'hFA, 1'b1, "op0309");
        run_op(8'hF3, 8'h49, 1'b0, 8'hAA, 1'b0, "opf349");
        run_op(8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, "op0000");
        run_op(8'hFF, 8'hFF, 1'b0, 8'h00, 1'b0, "opffff");
        run_op(8'h00, 8'hFF, 1'b1, 8'h00, 1'b1, "op00ff");

        // Extra starts during SHIFT and DONE must be ignored.
        check("model 4bc9", 32'(sub_ref(8'h4B, 8'hC9, 1'b0)), 32'h182);
        @(negedge clk);
        d0 = done_cnt;
        bus.start = 1'b1; bus.a = 8'h4B; bus.b = 8'hC9; bus.bin = 1'b0;
        @(negedge clk);                         // after E0
        bus.start = 1'b0;
        repeat (2) @(negedge clk);              // after E2
        bus.start = 1'b1; bus.a = 8'h11; bus.b = 8'h22; bus.bin = 1'b1;
        @(negedge clk);                         // after E3
        bus.start = 1'b0;
        check("ign held diff", 32'(bus.diff), 32'h00);
        check("ign held bout", 32'(bus.bout), 32'd1);
        check("ign busy", 32'(bus.busy), 32'd1);
        repeat (5) @(negedge clk);              // after E8: DONE
        check("ign done", 32'(bus.done), 32'd1);
        check("ign diff", 32'(bus.diff), 32'h82);
        check("ign bout", 32'(bus.bout), 32'd1);
        bus.start = 1'b1; bus.a = 8'h55; bus.b = 8'h66; bus.bin = 1'b1;
        @(negedge clk);                         // after E9
        bus.start = 1'b0;
        check("ign done low", 32'(bus.done), 32'd0);
        check("ign idle", 32'(bus.busy), 32'd0);
        @(negedge clk);
        check("ign not accepted", 32'(bus.busy), 32'd0);
        check("ign one done", 32'(done_cnt - d0), 32'd1);

        // Asynchronous reset mid-SHIFT aborts without a done pulse.
        @(negedge clk);
        bus.start = 1'b1; bus.a = 8'h12; bus.b = 8'h34; bus.bin = 1'b0;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (4) @(negedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst busy", 32'(bus.busy), 32'd0);
        check("arst done", 32'(bus.done), 32'd0);
        check("arst diff", 32'(bus.diff), 32'd0);
        check("arst bout", 32'(bus.bout), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        d0 = done_cnt;
        repeat (12) @(negedge clk);
        check("arst no done", 32'(done_cnt - d0), 32'd0);
        check("arst idle", 32'(bus.busy), 32'd0);
        run_op(8'h63, 8'h89, 1'b1, 8'hD9, 1'b1, "op6389");

        // Continuous start: one result every W+2 cycles.
        @(negedge clk);
        bus.start = 1'b1;
        bus.a = 8'($urandom); bus.b = 8'($urandom); bus.bin = 1'($urandom);
        last_done = -1;
        ndone = 0;
        for (int i = 1; i <= 200; i++) begin
            @(negedge clk);
            if (bus.done === 1'b1) begin
                if (last_done >= 0) check("stream period", 32'(cyc - last_done), 32'(W + 2));
                last_done = cyc;
                ndone++;
            end
            bus.a = 8'($urandom); bus.b = 8'($urandom); bus.bin = 1'($urandom);
        end
        bus.start = 1'b0;
        check("stream count", 32'(ndone), 32'd20);
        repeat (12) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
